// File: rtl/kbd_event_ctrl.sv
// PS/2 key-event controller: pops raw set-2 bytes from ps2_kbd, folds E0/F0 prefixes
// into 16-bit key events, buffers them and serves them over an STB/ACK register slave.
module kbd_event_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_ready,
    input  logic        kbd_overflow,
    output logic        kbd_rdn,
    input  logic        STB,
    input  logic        WE,
    input  logic [1:0]  ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        INT,
    output logic [1:0]  o_dbg_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE} state_t;

    state_t                r_state, w_next;
    logic [7:0]            r_byte;
    logic                  r_ext, r_brk;
    logic [15:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_sw_ovf, r_hw_ovf, r_int_en, r_int;
    logic                  r_stb_d, r_ack, r_we;
    logic [1:0]            r_addr;
    logic [3:0]            r_wdata;
    logic [31:0]           w_rdata;
    logic                  w_empty, w_full, w_prefix, w_push_req, w_push, w_pop, w_flush;
    logic                  w_bus_wr, w_bus_rd, w_accept, w_sw_clr, w_hw_clr, w_ctrl_wr;
    logic                  w_unused_dat;

    assign w_unused_dat = ^DAT_I[31:4];

    // Fetch FSM: kbd_rdn is low only while in FETCH, so async reset releases it at once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        kbd_rdn = 1'b1;
        case (r_state)
            S_IDLE:   if (kbd_ready) w_next = S_FETCH;
            S_FETCH:  begin
                kbd_rdn = 1'b0;
                w_next  = S_DECODE;
            end
            S_DECODE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign o_dbg_state = r_state;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_prefix   = (r_byte == 8'hE0) || (r_byte == 8'hF0);
    assign w_push_req = (r_state == S_DECODE) && !w_prefix;
    assign w_bus_wr   = r_ack && r_we;
    assign w_bus_rd   = r_ack && !r_we;
    assign w_accept   = STB && !r_stb_d;
    assign w_ctrl_wr  = w_bus_wr && (r_addr == 2'd2);
    assign w_flush    = w_ctrl_wr && r_wdata[1];
    assign w_sw_clr   = w_bus_wr && (r_addr == 2'd1) && r_wdata[2];
    assign w_hw_clr   = w_bus_wr && (r_addr == 2'd1) && r_wdata[3];
    assign w_pop      = w_bus_rd && (r_addr == 2'd0) && !w_empty;
    // A full FIFO drops the push even when a pop frees a slot in the same cycle.
    assign w_push     = w_push_req && !w_full && !w_flush;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_byte <= '0;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
        end else begin
            if (r_state == S_FETCH) r_byte <= kbd_data;
            if (w_flush) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_state == S_DECODE) begin
                if (r_byte == 8'hE0) r_ext <= 1'b1;
                else if (r_byte == 8'hF0) r_brk <= 1'b1;
                else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_brk, r_ext, 6'b0, r_byte};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set condition beats a clear-write in the same cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sw_ovf <= 1'b0;
            r_hw_ovf <= 1'b0;
            r_int_en <= 1'b0;
            r_int    <= 1'b0;
        end else begin
            r_sw_ovf <= (w_push_req && w_full) || (r_sw_ovf && !w_sw_clr);
            r_hw_ovf <= kbd_overflow || (r_hw_ovf && !w_hw_clr);
            if (w_ctrl_wr) r_int_en <= r_wdata[0];
            r_int <= r_int_en && !w_empty;
        end
    end

    // Accept on the rising edge of STB; the access executes during the ACK cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stb_d <= 1'b0;
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_stb_d <= STB;
            r_ack   <= w_accept;
            if (w_accept) begin
                r_we    <= WE;
                r_addr  <= ADDR;
                r_wdata <= DAT_I[3:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (r_addr)
            2'd0: if (!w_empty) w_rdata[15:0] = r_mem[r_rd_ptr];
            2'd1: begin
                w_rdata[0] = !w_empty;
                w_rdata[1] = w_full;
                w_rdata[2] = r_sw_ovf;
                w_rdata[3] = r_hw_ovf;
                w_rdata[8 +: DEPTH_LOG2 + 1] = r_count;
            end
            2'd2:    w_rdata[0] = r_int_en;
            default: w_rdata = '0;
        endcase
    end

    assign DAT_O = w_bus_rd ? w_rdata : '0;
    assign ACK   = r_ack;
    assign INT   = r_int;
endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: a scripted ps2_kbd byte source, a queue-based event model
// and a bus monitor that checks every read against an expected-value queue.
module tb_kbd_event_ctrl;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic        clk = 1'b0;
    logic        clrn;
    logic [7:0]  kbd_data = 8'h00;
    logic        kbd_ready = 1'b0;
    logic        kbd_overflow;
    logic        kbd_rdn;
    logic        STB, WE;
    logic [1:0]  ADDR;
    logic [31:0] DAT_I, DAT_O;
    logic        ACK, INT;
    logic [1:0]  dbg_state;

    kbd_event_ctrl #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_rdn(kbd_rdn), .STB(STB), .WE(WE),
        .ADDR(ADDR), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .INT(INT),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  src_q[$];
    logic [15:0] m_q[$];
    logic        m_ext, m_brk, m_sw, m_hw, m_int_en;
    int          pulses = 0;
    int          fed = 0;
    bit          pend_pop = 0;
    bit          prev_low = 0;
    bit          prev_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ext = 0; m_brk = 0; m_sw = 0; m_hw = 0; m_int_en = 0;
    endfunction

    // Key-event rules: E0 marks extended, F0 marks break, anything else emits an event.
    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (m_q.size() < DEPTH) m_q.push_back({m_brk, m_ext, 6'b0, b});
            else m_sw = 1;
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            2'd0: if (m_q.size() != 0) v = {16'h0, m_q[0]};
            2'd1: v = {19'b0, 5'(m_q.size()), 4'b0, m_hw, m_sw,
                       (m_q.size() == DEPTH), (m_q.size() != 0)};
            2'd2: v = {31'b0, m_int_en};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic void model_effect(input logic we, input logic [1:0] a, input logic [31:0] d);
        if (!we && a == 2'd0 && m_q.size() != 0) void'(m_q.pop_front());
        if (we && a == 2'd1) begin
            if (d[2]) m_sw = 0;
            if (d[3]) m_hw = 0;
        end
        if (we && a == 2'd2) begin
            m_int_en = d[0];
            if (d[1]) begin
                m_q.delete();
                m_ext = 0;
                m_brk = 0;
            end
        end
    endfunction

    // ps2_kbd stand-in: data changes only after the FETCH cycle has latched it.
    initial begin
        forever begin
            @(negedge clk);
            if (pend_pop) begin
                pend_pop = 0;
                if (src_q.size() != 0) void'(src_q.pop_front());
            end
            if (!kbd_rdn) begin
                pulses++;
                check("rdn_single_cycle", 32'(prev_low), 32'h0);
                check("rdn_with_data", 32'(src_q.size() != 0), 32'h1);
                if (src_q.size() != 0) model_byte(src_q[0]);
                pend_pop = 1;
            end
            prev_low  = !kbd_rdn;
            kbd_ready = (src_q.size() != 0);
            kbd_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
        end
    end

    // Bus monitor: every read ACK consumes one expected value.
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (ACK) begin
                check("ack_one_cycle", 32'(prev_ack), 32'h0);
                if (!WE) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got %08h expected none", DAT_O);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        check(nm, DAT_O, e);
                    end
                end
            end
            prev_ack = ACK;
        end
    end

    // Called at a negedge; returns at the posedge after STB has been sampled low.
    task automatic bus_xfer(input logic we, input logic [1:0] a, input logic [31:0] d);
        int n;
        if (!we) begin
            exp_q.push_back(model_read(a));
            name_q.push_back($sformatf("read_addr%0d", a));
        end
        STB = 1; WE = we; ADDR = a; DAT_I = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ACK && n < 8);
        if (!ACK) begin
            check("ack_timeout", 32'h0, 32'h1);
            if (!we) begin
                void'(exp_q.pop_back());
                void'(name_q.pop_back());
            end
        end
        @(posedge clk);
        #1;
        STB = 0; WE = 0;
        model_effect(we, a, d);
        @(posedge clk);
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clk);
        bus_xfer(1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_xfer(1'b1, a, d);
    endtask

    task automatic feed(input logic [7:0] b);
        src_q.push_back(b);
        fed++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((src_q.size() != 0 || pend_pop) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("drain_timeout", 32'h0, 32'h1);
            src_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_fetch();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kbd_rdn && n < 50);
        if (kbd_rdn) check("fetch_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, k, p;
        logic [7:0]  b;
        clrn = 0; STB = 0; WE = 0; ADDR = 0; DAT_I = 0; kbd_overflow = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rdn", 32'(kbd_rdn), 32'h1);
        check("reset_ack", 32'(ACK), 32'h0);
        check("reset_dat", DAT_O, 32'h0);
        check("reset_int", 32'(INT), 32'h0);
        clrn = 1;

        // Single code.
        feed(8'h1C); drain();
        rd(2'd1); rd(2'd0); rd(2'd1);

        // Extended break, then flags must be clear.
        feed(8'hE0); feed(8'hF0); feed(8'h75); drain();
        rd(2'd1); rd(2'd0);
        feed(8'h75); drain();
        rd(2'd0);

        // Interrupt timing.
        wr(2'd2, 32'h1);
        rd(2'd2);
        feed(8'h5A);
        wait_fetch();
        repeat (2) @(negedge clk);
        check("int_lag", 32'(INT), 32'h0);
        @(negedge clk);
        check("int_rise", 32'(INT), 32'h1);
        drain();
        rd(2'd0);
        @(negedge clk);
        check("int_fall", 32'(INT), 32'h0);
        wr(2'd2, 32'h0);

        // Overfill by one.
        for (int i = 0; i < DEPTH + 1; i++) feed(8'(8'h10 + i));
        drain();
        rd(2'd1);
        for (int i = 0; i < DEPTH; i++) rd(2'd0);
        rd(2'd0); rd(2'd1);
        wr(2'd1, 32'h4);
        rd(2'd1);

        // Hardware overflow sticky flag.
        @(negedge clk); kbd_overflow = 1;
        @(negedge clk); kbd_overflow = 0; m_hw = 1;
        repeat (3) @(negedge clk);
        rd(2'd1);
        wr(2'd1, 32'h4); rd(2'd1);
        wr(2'd1, 32'h8); rd(2'd1);

        // Pop coinciding with push, then flush coinciding with push.
        feed(8'h21); feed(8'h22); feed(8'h23); drain();
        feed(8'h44);
        wait_fetch();
        bus_xfer(1'b0, 2'd0, 32'h0);
        drain();
        rd(2'd1);
        feed(8'h55);
        wait_fetch();
        bus_xfer(1'b1, 2'd2, 32'h2);
        drain();
        rd(2'd1); rd(2'd0);

        // Reset during FETCH drops the pending prefix.
        feed(8'hE0);
        wait_fetch();
        #1;
        clrn = 0;
        #1;
        check("reset_mid_fetch_rdn", 32'(kbd_rdn), 32'h1);
        model_reset();
        repeat (2) @(negedge clk);
        clrn = 1;
        feed(8'h75); drain();
        rd(2'd0); rd(2'd1);

        // Randomized byte streams.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                p = $urandom_range(0, 9);
                if (p == 0) b = 8'hE0;
                else if (p == 1) b = 8'hF0;
                else begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hE0 || b == 8'hF0) b = 8'hE1;
                end
                feed(b);
            end
            drain();
            rd(2'd1);
            k = $urandom_range(0, m_q.size() + 1);
            for (int i = 0; i < k; i++) begin
                rd(2'd0);
                if ($urandom_range(0, 3) == 0) rd(2'd1);
            end
            case ($urandom_range(0, 3))
                0: wr(2'd1, 32'hC);
                1: wr(2'd0, $urandom);
                2: begin wr(2'd3, $urandom); rd(2'd3); end
                default: rd(2'd2);
            endcase
            rd(2'd1);
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("rdn_pulse_total", 32'(pulses), 32'(fed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kbd_event_ctrl.md
Name: kbd_event_ctrl

Overview:
- Controller that sequences the ps2_kbd byte FIFO.
- Pops one raw scan-code byte at a time via the ready/rdn handshake and folds the set-2 prefixes (E0 = extended, F0 = break) into one key-event word.
- Buffers events in an internal FIFO and exposes them to the CPU as a small register slave (STB/ACK bus) with a level interrupt.
- Replaces direct CPU polling of ps2_kbd.

Parameters:
DEPTH_LOG2, 4, event FIFO depth = 2^DEPTH_LOG2 entries (16).

Ports:
clk  in  1  CPU clock; all logic on rising edge.
clrn  in  1  asynchronous active-low reset.
kbd_data  in  8  byte from ps2_kbd.
kbd_ready  in  1  ps2_kbd has a byte available.
kbd_overflow  in  1  ps2_kbd internal FIFO overflowed.
kbd_rdn  out  1  active-low pop strobe to ps2_kbd.
STB  in  1  bus access strobe.
WE  in  1  1 = write, 0 = read.
ADDR  in  2  register select.
DAT_I  in  32  write data.
DAT_O  out  32  read data; valid while ACK = 1.
ACK  out  1  access acknowledge.
INT  out  1  interrupt request (level).

Behaviour:
- Reset (clrn = 0, async):
  - kbd_rdn = 1, ACK = 0, DAT_O = 0, INT = 0.
  - FIFO empty; ext/brk flags = 0; sticky flags = 0; int_en = 0.
  - FSM = IDLE.
- Event word (16 bits, zero-extended on DAT_O): [15] break, [14] extended, [13:8] 0, [7:0] scan code.
- Fetch FSM:
  - IDLE: if kbd_ready = 1, go to FETCH.
  - FETCH: kbd_rdn = 0 for exactly this one cycle; latch kbd_data into byte_q; go to DECODE.
  - DECODE:
    - byte_q = E0: ext <= 1.
    - byte_q = F0: brk <= 1.
    - Otherwise: push {brk, ext, byte_q}, then clear ext and brk. The push is dropped if the FIFO is full; in that case set sw_ovf. Flags are cleared whether or not the push succeeds.
    - Always return to IDLE.
  - Each byte therefore takes 3 cycles. kbd_rdn is never low for two consecutive cycles.
  - An event is readable on the cycle after DECODE.
  - E1 and all other non-prefix bytes are pushed as plain codes.
- Sticky hardware overflow: hw_ovf is set on any cycle where kbd_overflow = 1.
- Register map (ADDR):
  - 0 EVENT, read: head event, and pops on the ACK cycle. Reading while empty returns 0 with no pop. Writes are ignored.
  - 1 STATUS, read: [0] not_empty, [1] full, [2] sw_ovf, [3] hw_ovf, [8+DEPTH_LOG2:8] count. Write: 1 in bit 2 clears sw_ovf; 1 in bit 3 clears hw_ovf.
  - 2 CTRL: [0] int_en (read/write). [1] flush: write-only, self-clearing, reads 0. Flush empties the FIFO and clears ext/brk.
  - 3: reads 0; writes ignored.
- Bus handshake:
  - ACK is registered: asserted the cycle after STB is first seen high, held for one cycle, then low.
  - The master drops STB after ACK. A new access is accepted only after STB has been low for at least one cycle.
  - Read side effects (pop) and writes take effect on the ACK cycle only.
- INT = int_en & not_empty, registered: follows the state with one cycle of lag.
- Simultaneous events:
  - Push and pop in the same cycle: both occur; count is unchanged; the popped word is the old head.
  - Push when full: dropped, even if a pop happens in the same cycle.
  - Flush and push in the same cycle: flush wins, and the pushed event is discarded.
  - Flush and sw_ovf set in the same cycle: sw_ovf is still set.
  - Clear-write to a sticky flag and its set condition in the same cycle: set wins.
- Pointers wrap modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits, range 0 to 2^DEPTH_LOG2.
- Reset mid-operation (e.g. during FETCH): kbd_rdn returns to 1 immediately (async). A partially decoded prefix is lost.

Test Plan:
- Reset, then feed byte 1C with kbd_ready high -> exactly one kbd_rdn low pulse; STATUS reads count = 1, not_empty = 1; EVENT read returns 0000001C; a following STATUS read returns count = 0.
- Feed E0, F0, 75 -> three kbd_rdn pulses, each separated by at least 2 cycles; exactly one event, 0000C075; ext/brk clear afterwards (next byte 75 yields 00000075).
- Write CTRL = 1, then push one event -> INT rises within 1 cycle of the event becoming visible; INT falls 1 cycle after the EVENT read empties the FIFO.
- Push 17 codes (DEPTH_LOG2 = 4) with no reads -> STATUS = full, count = 16, sw_ovf = 1; the 16 events read back in order; the 17th is lost; writing STATUS bit 2 = 1 clears sw_ovf.
- Pulse kbd_overflow for one cycle -> hw_ovf = 1 and remains set until STATUS is written with bit 3 = 1.
- EVENT read ACK coinciding with a DECODE push into a FIFO holding 3 events -> old head returned, count stays 3; CTRL flush in the same cycle as a push -> count = 0, no event retained.
